advtim_cap_sched: RTL and testbench

ADVTIM_CAP_SCHED -- requirements
Module: advtim_cap_sched

---
 rtl/advtim_cap_sched.sv | 118 +++++++++++
 tb/tb_advtim_cap_sched.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/advtim_cap_sched.sv
// advtim_cap_sched: round-robin scheduler sharing one capture core among four channels
module advtim_cap_sched #(
    parameter int TMO_W = 16
) (
    input  logic             pe_cap_clk,
    input  logic             pe_cap_rst,
    input  logic [3:0]       r_cap_en,
    input  logic [3:0]       r_ch_ic1m,
    input  logic [TMO_W-1:0] r_tmo,
    input  logic [3:0]       ch_req,
    input  logic             core_tim_end,
    input  logic [15:0]      core_ifr,
    input  logic [15:0]      core_ilr,
    input  logic [15:0]      core_ifc,
    input  logic [15:0]      core_ilc,
    output logic             core_tim_enable,
    output logic             core_logic_clr,
    output logic             core_ic1m,
    output logic [1:0]       core_sel,
    input  logic [3:0]       res_ack,
    input  logic [1:0]       rd_sel,
    output logic [15:0]      rd_ifr,
    output logic [15:0]      rd_ilr,
    output logic [15:0]      rd_ifc,
    output logic [15:0]      rd_ilc,
    output logic [3:0]       res_valid,
    output logic [3:0]       err_tmo,
    output logic             int_done,
    output logic             int_tmo,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, START, RUN, CLR} state_t;
    state_t            r_state;
    state_t            w_next;
    logic [1:0]        r_last;
    logic [TMO_W-1:0]  r_cnt;
    logic [3:0][63:0]  r_bank;
    logic [3:0]        w_elig;
    logic [1:0]        w_grant;
    logic              w_done;
    logic              w_tmo;
    logic              w_abort;
    logic [3:0]        w_set_v;
    logic [3:0]        w_set_e;

    assign w_elig  = ch_req & r_cap_en & ~res_valid & ~err_tmo;
    assign w_done  = r_state == RUN && core_tim_end;
    assign w_tmo   = r_state == RUN && !core_tim_end && r_tmo != '0 && r_cnt == r_tmo - TMO_W'(1);
    assign w_abort = r_state == RUN && !core_tim_end && !w_tmo && !r_cap_en[core_sel];
    assign w_set_v = w_done ? 4'b0001 << core_sel : 4'b0000;
    assign w_set_e = w_tmo ? 4'b0001 << core_sel : 4'b0000;
    assign {rd_ifr, rd_ilr, rd_ifc, rd_ilc} = r_bank[rd_sel];

    // First eligible channel after the last grant; descending scan lets the nearest one win
    always_comb begin
        w_grant = r_last;
        for (int k = 4; k >= 1; k--)
            if (w_elig[r_last + 2'(k)]) w_grant = r_last + 2'(k);
    end

    // State register
    always_ff @(posedge pe_cap_clk)
        r_state <= pe_cap_rst ? IDLE : w_next;

    // Next-state: START and CLR last one clock, RUN ends on done, timeout or abort
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  w_next = |w_elig ? START : IDLE;
            START: w_next = RUN;
            RUN:   w_next = (w_done || w_tmo || w_abort) ? CLR : RUN;
            CLR:   w_next = IDLE;
        endcase
    end

    // Core control and interrupt pulses decoded from state and exit events
    always_comb begin
        core_tim_enable = r_state == RUN;
        core_logic_clr  = r_state == START || r_state == CLR;
        busy            = r_state != IDLE;
        int_done        = w_done && !pe_cap_rst;
        int_tmo         = w_tmo && !pe_cap_rst;
    end

    // Grant latch (held until the next grant), round-robin pointer, saturating timeout counter
    always_ff @(posedge pe_cap_clk) begin
        if (pe_cap_rst) begin
            r_last    <= 2'd3;
            core_sel  <= 2'd0;
            core_ic1m <= 1'b0;
            r_cnt     <= '0;
        end else begin
            if (r_state == IDLE && |w_elig) begin
                core_sel  <= w_grant;
                core_ic1m <= r_ch_ic1m[w_grant];
            end
            if (r_state == CLR) r_last <= core_sel;
            r_cnt <= r_state == START ? '0 : (r_state == RUN && r_cnt != '1) ? r_cnt + TMO_W'(1) : r_cnt;
        end
    end

    // Sticky result/timeout flags: ack clears, a same-cycle set wins
    always_ff @(posedge pe_cap_clk) begin
        if (pe_cap_rst) begin
            res_valid <= '0;
            err_tmo   <= '0;
        end else begin
            res_valid <= (res_valid & ~res_ack) | w_set_v;
            err_tmo   <= (err_tmo & ~res_ack) | w_set_e;
        end
    end

    // Result bank, written only when the core finishes a capture
    always_ff @(posedge pe_cap_clk) begin
        if (pe_cap_rst) r_bank <= '0;
        else if (w_done) r_bank[core_sel] <= {core_ifr, core_ilr, core_ifc, core_ilc};
    end
endmodule

// File: tb/tb_advtim_cap_sched.sv
// tb_advtim_cap_sched: randomized transaction-level checks of the capture scheduler
module tb_advtim_cap_sched;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  r_cap_en = '0, r_ch_ic1m = '0, ch_req = '0, res_ack = '0;
    logic [15:0] r_tmo = '0;
    logic        core_tim_end = 1'b0;
    logic [15:0] core_ifr = '0, core_ilr = '0, core_ifc = '0, core_ilc = '0;
    logic [1:0]  rd_sel = '0;
    logic        core_tim_enable, core_logic_clr, core_ic1m, int_done, int_tmo, busy;
    logic [1:0]  core_sel;
    logic [15:0] rd_ifr, rd_ilr, rd_ifc, rd_ilc;
    logic [3:0]  res_valid, err_tmo;

    int checks = 0;
    int failures = 0;

    logic [1:0]  m_last;
    logic [63:0] m_bank [4];
    logic [3:0]  m_valid, m_err;

    advtim_cap_sched #(.TMO_W(16)) dut (
        .pe_cap_clk(clk), .pe_cap_rst(rst), .r_cap_en(r_cap_en), .r_ch_ic1m(r_ch_ic1m),
        .r_tmo(r_tmo), .ch_req(ch_req), .core_tim_end(core_tim_end),
        .core_ifr(core_ifr), .core_ilr(core_ilr), .core_ifc(core_ifc), .core_ilc(core_ilc),
        .core_tim_enable(core_tim_enable), .core_logic_clr(core_logic_clr),
        .core_ic1m(core_ic1m), .core_sel(core_sel), .res_ack(res_ack), .rd_sel(rd_sel),
        .rd_ifr(rd_ifr), .rd_ilr(rd_ilr), .rd_ifc(rd_ifc), .rd_ilc(rd_ilc),
        .res_valid(res_valid), .err_tmo(err_tmo), .int_done(int_done), .int_tmo(int_tmo),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_last  = 2'd3;
        m_valid = '0;
        m_err   = '0;
        for (int i = 0; i < 4; i++) m_bank[i] = '0;
    endtask

    task automatic check_banks(input string tag);
        for (int r = 0; r < 4; r++) begin
            rd_sel = 2'(r);
            #1;
            checks++;
            if ({rd_ifr, rd_ilr, rd_ifc, rd_ilc} !== m_bank[r]) begin
                failures++;
                $display("FAIL %s bank[%0d]: got %h expected %h", tag, r, {rd_ifr, rd_ilr, rd_ifc, rd_ilc}, m_bank[r]);
            end
        end
    endtask

    // One complete grant: core finishes in RUN clock l, timeout tmo (0 = off), abort in clock ab (0 = none)
    task automatic run_txn(input logic [3:0] mask, input int l, input int tmo, input int ab,
                           input bit ack_late, input bit ack, input logic [63:0] dat, input string tag);
        int g, stop;
        bit done, to;
        logic [3:0] ic;
        g = -1;
        for (int k = 1; k <= 4; k++)
            if (g < 0 && mask[(int'(m_last) + k) % 4]) g = (int'(m_last) + k) % 4;
        ic = 4'($urandom);
        r_ch_ic1m = ic;
        r_tmo = 16'(tmo);
        r_cap_en = 4'hF;
        ch_req = mask;
        stop = l;
        if (tmo != 0 && tmo < stop) stop = tmo;
        if (ab != 0 && ab < stop) stop = ab;
        done = stop == l;
        to = !done && tmo != 0 && stop == tmo;
        tick();
        checks++;
        if ({core_logic_clr, core_tim_enable, busy, core_sel, core_ic1m} !== {1'b1, 1'b0, 1'b1, 2'(g), ic[g]}) begin
            failures++;
            $display("FAIL %s start: clr/en/busy/sel/ic1m=%b%b%b/%0d/%b expected 101/%0d/%b",
                     tag, core_logic_clr, core_tim_enable, busy, core_sel, core_ic1m, g, ic[g]);
        end
        r_ch_ic1m = ~ic;
        for (int n = 1; n <= stop; n++) begin
            tick();
            ch_req = '0;
            checks++;
            if ({core_tim_enable, core_logic_clr} !== 2'b10) begin
                failures++;
                $display("FAIL %s run clk %0d: en/clr=%b%b expected 10", tag, n, core_tim_enable, core_logic_clr);
            end
            core_tim_end = n == l;
            {core_ifr, core_ilr, core_ifc, core_ilc} = dat;
            if (n == ab) r_cap_en = 4'hF & ~(4'b0001 << g);
            if (n == stop && ack_late) res_ack = 4'hF;
            #1;
            checks++;
            if ({int_done, int_tmo} !== {n == l, !(n == l) && tmo != 0 && n == tmo}) begin
                failures++;
                $display("FAIL %s irq clk %0d: done/tmo=%b%b expected %b%b", tag, n, int_done, int_tmo,
                         n == l, !(n == l) && tmo != 0 && n == tmo);
            end
        end
        if (ack_late) begin
            m_valid = '0;
            m_err = '0;
        end
        if (done) begin
            m_valid[g] = 1'b1;
            m_bank[g] = dat;
        end
        if (to) m_err[g] = 1'b1;
        tick();
        core_tim_end = 1'b0;
        res_ack = '0;
        r_cap_en = 4'hF;
        #1;
        checks++;
        if ({core_logic_clr, core_tim_enable, busy, int_done, int_tmo, core_sel, core_ic1m} !==
            {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'(g), ic[g]}) begin
            failures++;
            $display("FAIL %s clr: clr/en/busy/done/tmo=%b%b%b%b%b sel=%0d ic1m=%b expected 10100 sel=%0d ic1m=%b",
                     tag, core_logic_clr, core_tim_enable, busy, int_done, int_tmo, core_sel, core_ic1m, g, ic[g]);
        end
        checks++;
        if ({res_valid, err_tmo} !== {m_valid, m_err}) begin
            failures++;
            $display("FAIL %s flags: valid/err=%b/%b expected %b/%b", tag, res_valid, err_tmo, m_valid, m_err);
        end
        tick();
        checks++;
        if ({busy, core_tim_enable, core_logic_clr} !== 3'b000) begin
            failures++;
            $display("FAIL %s idle: busy/en/clr=%b%b%b expected 000", tag, busy, core_tim_enable, core_logic_clr);
        end
        m_last = 2'(g);
        check_banks(tag);
        if (ack) begin
            res_ack = 4'hF;
            tick();
            res_ack = '0;
            m_valid = '0;
            m_err = '0;
            checks++;
            if ({res_valid, err_tmo} !== 8'h00) begin
                failures++;
                $display("FAIL %s ack: valid/err=%b/%b expected 0000/0000", tag, res_valid, err_tmo);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        model_reset();
        checks++;
        if ({core_tim_enable, core_logic_clr, core_ic1m, core_sel, res_valid, err_tmo, int_done, int_tmo, busy} !== '0) begin
            failures++;
            $display("FAIL reset outputs: en=%b clr=%b ic1m=%b sel=%0d valid=%b err=%b done=%b tmo=%b busy=%b expected all 0",
                     core_tim_enable, core_logic_clr, core_ic1m, core_sel, res_valid, err_tmo, int_done, int_tmo, busy);
        end
        check_banks("reset");
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        run_txn(4'b0001, 10, 0, 0, 1'b0, 1'b1, {16'h0012, 16'h0345, 16'h0678, 16'h09ab}, "single");
    endtask

    task automatic test_blocked();
        run_txn(4'b0100, 3, 0, 0, 1'b0, 1'b0, {$urandom, $urandom}, "blocked_txn");
        ch_req = 4'b0100;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL blocked regrant: busy=%b expected 0", busy);
        end
        ch_req = '0;
        res_ack = 4'hF;
        tick();
        res_ack = '0;
        m_valid = '0;
        m_err = '0;
    endtask

    task automatic test_round_robin();
        test_reset();
        for (int i = 0; i < 5; i++)
            run_txn(4'hF, 2 + i, 0, 0, 1'b0, 1'b1, {$urandom, $urandom}, "round_robin");
    endtask

    task automatic test_timeout();
        run_txn(4'($urandom_range(1, 15)), 1000, 5, 0, 1'b0, 1'b1, {$urandom, $urandom}, "timeout");
        run_txn(4'($urandom_range(1, 15)), 1000, 1, 0, 1'b0, 1'b1, {$urandom, $urandom}, "timeout_one");
    endtask

    task automatic test_collision();
        run_txn(4'($urandom_range(1, 15)), 5, 5, 0, 1'b0, 1'b1, {$urandom, $urandom}, "collision");
    endtask

    task automatic test_abort();
        run_txn(4'($urandom_range(1, 15)), 1000, 0, 3, 1'b0, 1'b1, {$urandom, $urandom}, "abort");
    endtask

    task automatic test_set_wins();
        run_txn(4'hF, 4, 0, 0, 1'b1, 1'b1, {$urandom, $urandom}, "set_wins_done");
        run_txn(4'hF, 1000, 3, 0, 1'b1, 1'b1, {$urandom, $urandom}, "set_wins_tmo");
    endtask

    task automatic test_reset_mid_run();
        r_cap_en = 4'hF;
        ch_req = 4'b0001 << $urandom_range(0, 3);
        tick();
        ch_req = '0;
        tick();
        tick();
        rst = 1'b1;
        core_tim_end = 1'b1;
        tick();
        model_reset();
        checks++;
        if ({core_tim_enable, core_logic_clr, core_ic1m, core_sel, res_valid, err_tmo, int_done, int_tmo, busy} !== '0) begin
            failures++;
            $display("FAIL reset_mid_run: en=%b clr=%b ic1m=%b sel=%0d valid=%b err=%b done=%b tmo=%b busy=%b expected all 0",
                     core_tim_enable, core_logic_clr, core_ic1m, core_sel, res_valid, err_tmo, int_done, int_tmo, busy);
        end
        rst = 1'b0;
        core_tim_end = 1'b0;
        check_banks("reset_mid_run");
        run_txn(4'hF, 3, 0, 0, 1'b0, 1'b1, {$urandom, $urandom}, "after_reset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++)
            run_txn(4'($urandom_range(1, 15)), $urandom_range(1, 12), $urandom_range(0, 12),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : 0,
                    1'($urandom_range(0, 1)), 1'b1, {$urandom, $urandom}, "random");
    endtask

    initial begin
        test_reset();
        test_single();
        test_blocked();
        test_round_robin();
        test_timeout();
        test_collision();
        test_abort();
        test_set_wins();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
